// File: rtl/sd_upsize.sv
// srdy/drdy width upsizer: gathers narrow beats into one wide word with a per-lane
// valid mask; c_last closes a word early so packet tails leave as partial words.
module sd_upsize #(
    parameter int in_width = 8,
    parameter int ratio    = 4,
    parameter int lw       = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      c_srdy,
    output logic                      c_drdy,
    input  logic [in_width-1:0]       c_data,
    input  logic                      c_last,
    output logic                      p_srdy,
    input  logic                      p_drdy,
    output logic [in_width*ratio-1:0] p_data,
    output logic [ratio-1:0]          p_mask,
    output logic                      p_last
);

    localparam int              OUT_W     = in_width * ratio;
    localparam logic [lw-1:0]   LAST_LANE = lw'(ratio - 1);

    if (ratio < 2 || lw != $clog2(ratio)) begin : g_bad_params
        $error("sd_upsize: ratio must be >= 2 and lw must equal clog2(ratio)");
    end

    // Accumulator
    logic [OUT_W-1:0] r_acc_data;
    logic [ratio-1:0] r_acc_mask;
    logic [lw-1:0]    r_lane;

    // Output register
    logic [OUT_W-1:0] r_p_data;
    logic [ratio-1:0] r_p_mask;
    logic             r_p_last;
    logic             r_p_srdy;

    logic             w_c_xfer;
    logic             w_p_xfer;
    logic             w_complete;
    logic [OUT_W-1:0] w_merged_data;
    logic [ratio-1:0] w_merged_mask;

    // Accept whenever the output register is empty or being drained this cycle.
    assign c_drdy   = !r_p_srdy || p_drdy;
    assign w_c_xfer = c_srdy && c_drdy;
    assign w_p_xfer = r_p_srdy && p_drdy;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_merged_data = r_acc_data;
        w_merged_mask = r_acc_mask;
        w_merged_data[r_lane*in_width +: in_width] = c_data;
        w_merged_mask[r_lane] = 1'b1;
        w_complete = (r_lane == LAST_LANE) || c_last;
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates
    // from pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc_data <= '0;
            r_acc_mask <= '0;
            r_lane     <= '0;
            r_p_data   <= '0;
            r_p_mask   <= '0;
            r_p_last   <= 1'b0;
            r_p_srdy   <= 1'b0;
        end else begin
            if (w_c_xfer && w_complete) begin
                // Completing beat bypasses the accumulator straight into the output register.
                r_p_data   <= w_merged_data;
                r_p_mask   <= w_merged_mask;
                r_p_last   <= c_last;
                r_p_srdy   <= 1'b1;
                r_acc_data <= '0;
                r_acc_mask <= '0;
                r_lane     <= '0;
            end else begin
                if (w_c_xfer) begin
                    r_acc_data <= w_merged_data;
                    r_acc_mask <= w_merged_mask;
                    r_lane     <= r_lane + lw'(1);
                end
                if (w_p_xfer) begin
                    r_p_srdy <= 1'b0;
                end
            end
        end
    end

    assign p_srdy = r_p_srdy;
    assign p_data = r_p_data;
    assign p_mask = r_p_mask;
    assign p_last = r_p_last;

endmodule
